// File: rtl/match_pkg.sv
// match_pkg: shared FSM state, coordinate slicing, distance helpers
// for the parallel descriptor match controller.
package match_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Widest descriptor the popcount helper accepts.
  localparam int MAX_DES_W = 1024;
  localparam int PC_W      = 11;

  // Coordinate word is {row, col}; col holds the low cw/2 bits.
  function automatic logic [31:0] coor_col(
    input logic [31:0] c,
    input int          cw
  );
    logic [31:0] m;
    m = (32'd1 << (cw / 2)) - 32'd1;
    return c & m;
  endfunction

  function automatic logic [31:0] coor_row(
    input logic [31:0] c,
    input int          cw
  );
    logic [31:0] m;
    m = (32'd1 << (cw - cw / 2)) - 32'd1;
    return (c >> (cw / 2)) & m;
  endfunction

  function automatic logic [31:0] abs_diff(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [PC_W-1:0] popcount(
    input logic [MAX_DES_W-1:0] v
  );
    logic [PC_W-1:0] s;
    s = '0;
    for (int i = 0; i < MAX_DES_W; i++)
      s = s + PC_W'(v[i]);
    return s;
  endfunction

endpackage

// File: rtl/match_lane.sv
// match_lane: one main descriptor, two Hamming units, running minima.
// Ports: clear/load/en_p/en_r controls, RAM words in, best coords/minima out.
module match_lane
  import match_pkg::*;
#(
  parameter int DES_W  = 128,
  parameter int COOR_W = 20,
  parameter int HD_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    en_p,
  input  logic                    en_r,
  input  logic [COOR_W+DES_W-1:0] l_data,
  input  logic [COOR_W+DES_W-1:0] p_data,
  input  logic [COOR_W+DES_W-1:0] r_data,
  output logic [COOR_W-1:0]       coor_m,
  output logic [COOR_W-1:0]       coor_p,
  output logic [COOR_W-1:0]       coor_r,
  output logic [HD_W-1:0]         min_p,
  output logic [HD_W-1:0]         min_r
);

  localparam int WW = COOR_W + DES_W;

  logic [DES_W-1:0] main_q;
  logic [HD_W-1:0]  hd_p;
  logic [HD_W-1:0]  hd_r;

  // Saturating Hamming distance.
  function automatic logic [HD_W-1:0] hd(
    input logic [DES_W-1:0] a,
    input logic [DES_W-1:0] b
  );
    logic [MAX_DES_W-1:0] x;
    logic [31:0]          pc;
    logic [HD_W-1:0]      r;
    x             = '0;
    x[DES_W-1:0]  = a ^ b;
    pc            = 32'(popcount(x));
    r             = pc[HD_W-1:0];
    if (pc > 32'((64'd1 << HD_W) - 64'd1))
      r = '1;
    return r;
  endfunction

  assign hd_p = hd(main_q, p_data[DES_W-1:0]);
  assign hd_r = hd(main_q, r_data[DES_W-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      coor_m <= '0;
      coor_p <= '0;
      coor_r <= '0;
      min_p  <= '0;
      min_r  <= '0;
    end else if (clear) begin
      coor_p <= '0;
      coor_r <= '0;
      min_p  <= '1;
      min_r  <= '1;
    end else begin
      if (load) begin
        main_q <= l_data[DES_W-1:0];
        coor_m <= l_data[WW-1:DES_W];
      end
      // Strictly smaller only: earliest address keeps a tie.
      if (en_p && hd_p < min_p) begin
        min_p  <= hd_p;
        coor_p <= p_data[WW-1:DES_W];
      end
      if (en_r && hd_r < min_r) begin
        min_r  <= hd_r;
        coor_r <= r_data[WW-1:DES_W];
      end
    end
  end

endmodule

// File: rtl/match_ctrl_par.sv
// match_ctrl_par: batch-loads main descriptors, streams P/R RAMs past all
// lanes, emits qualified {coorR, coorP, coorM} on a valid/ready stream.
module match_ctrl_par
  import match_pkg::*;
#(
  parameter int          N_LANES  = 4,
  parameter int          DES_W    = 128,
  parameter int          COOR_W   = 20,
  parameter int          ADDR_W   = 10,
  parameter int          HD_W     = 8,
  parameter int          MATCH_TH = 10,
  parameter int          PSR      = 5,
  parameter int          ROW_TOL  = 1,
  parameter logic [1:0]  MODE     = 2'b11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       cnt_l,
  input  logic [ADDR_W-1:0]       cnt_p,
  input  logic [ADDR_W-1:0]       cnt_r,
  output logic [ADDR_W-1:0]       l_addr,
  output logic [ADDR_W-1:0]       p_addr,
  output logic [ADDR_W-1:0]       r_addr,
  input  logic [COOR_W+DES_W-1:0] l_data,
  input  logic [COOR_W+DES_W-1:0] p_data,
  input  logic [COOR_W+DES_W-1:0] r_data,
  output logic [3*COOR_W-1:0]     dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic                    match_done
);

  localparam int KW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int CW = ADDR_W + 1;

  state_t              state;
  logic [ADDR_W-1:0]   cl, cp, cr, base;
  logic [CW-1:0]       c, a;
  logic [KW-1:0]       k;
  logic                pv, rv;
  logic [N_LANES-1:0]  lane_en;

  logic [ADDR_W-1:0]   rem, mx, base_nxt;
  logic [CW-1:0]       n;
  logic                scan_last, out_free, k_last, clr, qual;

  logic [N_LANES-1:0]  ld, ep, er;
  logic [COOR_W-1:0]   cm_s [N_LANES];
  logic [COOR_W-1:0]   cp_s [N_LANES];
  logic [COOR_W-1:0]   cr_s [N_LANES];
  logic [HD_W-1:0]     mp_s [N_LANES];
  logic [HD_W-1:0]     mr_s [N_LANES];

  logic [COOR_W-1:0]   cm_k, cp_k, cr_k;
  logic [HD_W-1:0]     mp_k, mr_k;
  logic [31:0]         col_d, row_d;

  // Address that sticks at cnt-1 once the stream is exhausted.
  function automatic logic [ADDR_W-1:0] clamp(
    input logic [CW-1:0]     x,
    input logic [ADDR_W-1:0] cnt
  );
    logic [ADDR_W-1:0] r;
    r = '0;
    if (x < {1'b0, cnt})
      r = x[ADDR_W-1:0];
    else if (cnt != '0)
      r = cnt - 1'b1;
    return r;
  endfunction

  always_comb begin
    rem       = cl - base;
    n         = ({1'b0, rem} < CW'(N_LANES)) ?
                {1'b0, rem} : CW'(N_LANES);
    base_nxt  = base + n[ADDR_W-1:0];
    mx        = (cp > cr) ? cp : cr;
    scan_last = (a + CW'(1)) >= {1'b0, mx};
    out_free  = !dout_valid || dout_ready;
    k_last    = (k == KW'(N_LANES - 1));
    clr       = (state == S_LOAD) && (c == '0);
  end

  always_comb begin
    l_addr = '0;
    p_addr = '0;
    r_addr = '0;
    if (state == S_LOAD && c < n)
      l_addr = base + c[ADDR_W-1:0];
    if (state == S_SCAN) begin
      p_addr = clamp(a, cp);
      r_addr = clamp(a, cr);
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign ld[i] = (state == S_LOAD) && (c == CW'(i + 1));
    assign ep[i] = pv && lane_en[i];
    assign er[i] = rv && lane_en[i];

    match_lane #(
      .DES_W  (DES_W),
      .COOR_W (COOR_W),
      .HD_W   (HD_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (clr),
      .load   (ld[i]),
      .en_p   (ep[i]),
      .en_r   (er[i]),
      .l_data (l_data),
      .p_data (p_data),
      .r_data (r_data),
      .coor_m (cm_s[i]),
      .coor_p (cp_s[i]),
      .coor_r (cr_s[i]),
      .min_p  (mp_s[i]),
      .min_r  (mr_s[i])
    );
  end

  always_comb begin
    cm_k  = cm_s[k];
    cp_k  = cp_s[k];
    cr_k  = cr_s[k];
    mp_k  = mp_s[k];
    mr_k  = mr_s[k];
    col_d = abs_diff(coor_col(32'(cr_k), COOR_W),
                     coor_col(32'(cm_k), COOR_W));
    row_d = abs_diff(coor_row(32'(cr_k), COOR_W),
                     coor_row(32'(cm_k), COOR_W));
    qual  = lane_en[k] &&
            (!MODE[0] || (32'(mp_k) < 32'(MATCH_TH))) &&
            (!MODE[1] || ((32'(mr_k) < 32'(MATCH_TH)) &&
                          (col_d < 32'(PSR)) &&
                          (row_d <= 32'(ROW_TOL))));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cl    <= '0;
      cp    <= '0;
      cr    <= '0;
      base  <= '0;
      c     <= '0;
      a     <= '0;
      k     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cl    <= cnt_l;
            cp    <= cnt_p;
            cr    <= cnt_r;
            base  <= '0;
            c     <= '0;
            state <= (cnt_l == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (c == n) begin
            c     <= '0;
            a     <= '0;
            state <= S_SCAN;
          end else begin
            c <= c + CW'(1);
          end
        end
        S_SCAN: begin
          if (scan_last)
            state <= S_DRAIN;
          else
            a <= a + CW'(1);
        end
        S_DRAIN: begin
          k     <= '0;
          state <= S_EMIT;
        end
        S_EMIT: begin
          // A held result blocks the next lane from being examined.
          if (out_free) begin
            if (k_last) begin
              base  <= base_nxt;
              c     <= '0;
              state <= (base_nxt == cl) ? S_DONE : S_LOAD;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        S_DONE: begin
          if (out_free)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stream valids trail the address by one cycle, like the RAM data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv      <= 1'b0;
      rv      <= 1'b0;
      lane_en <= '0;
    end else begin
      pv <= (state == S_SCAN) && (a < {1'b0, cp});
      rv <= (state == S_SCAN) && (a < {1'b0, cr});
      if (clr) begin
        for (int i = 0; i < N_LANES; i++)
          lane_en[i] <= (CW'(i) < n);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else if (out_free) begin
      if (state == S_EMIT && qual) begin
        dout_valid <= 1'b1;
        dout       <= {cr_k, cp_k, cm_k};
      end else begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign match_done = (state == S_DONE) && out_free;

endmodule

// File: doc/match_ctrl_par.md
# match_ctrl_par

Parametrised successor of the four-lane stereo/temporal match controller. It loads up to `N_LANES` main (current-left) descriptors per batch. It then streams the previous-left and current-right descriptor RAMs past every lane in parallel, and each lane keeps the minimum Hamming distance per slave set. Qualified triplets are emitted on a valid/ready stream, which replaces the unthrottled write-enable output. The block sits between the three descriptor RAMs and the match-result TX FIFO.

## Interface
Parameters:
- `N_LANES`, 4: main descriptors matched per batch (1..16)
- `DES_W`, 128: descriptor bits per RAM word
- `COOR_W`, 20: coordinate bits, `{row[COOR_W-1:COOR_W/2], col[COOR_W/2-1:0]}`, stored above the descriptor
- `ADDR_W`, 10: RAM address and count width
- `HD_W`, 8: distance width. Saturates at all-ones.
- `MATCH_TH`, 10: accept if distance < `MATCH_TH`
- `PSR`, 5: accept if |colR − colM| < `PSR`
- `ROW_TOL`, 1: accept if |rowR − rowM| ≤ `ROW_TOL`
- `MODE`, 2'b11: bit0 = temporal check enabled, bit1 = stereo check enabled. A disabled check always passes.

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle pulse. Sampled only in IDLE.
- `cnt_l`, `cnt_p`, `cnt_r` in `ADDR_W`: descriptor counts of the left, previous and right RAMs. Captured at `start`.
- `l_addr`, `p_addr`, `r_addr` out `ADDR_W`: RAM read addresses
- `l_data`, `p_data`, `r_data` in `COOR_W+DES_W`: RAM read data, valid 1 cycle after the address
- `dout` out `3*COOR_W`: `{coorR, coorP, coorM}`
- `dout_valid` out 1: result valid
- `dout_ready` in 1: sink accepts the result
- `busy` out 1: high whenever the state is not IDLE
- `match_done` out 1: one-cycle pulse at the end of a frame

## Operation
- States: IDLE, LOAD, SCAN, DRAIN, EMIT, DONE.
- **IDLE:** all addresses are 0. On `start`, latch the counts and `base` = 0.
  - If `cnt_l` = 0, go to DONE.
  - Otherwise go to LOAD.
- **LOAD:** issue `l_addr` = `base`+k for k = 0..n−1, where n = min(`N_LANES`, `cnt_l`−`base`).
  - Lane k captures `l_data` one cycle after its address.
  - `lane_en[k]` = (k < n).
  - All lane minima clear to all-ones and all lane indices clear to 0.
  - Go to SCAN after the last capture.
- **SCAN:** the address counter `a` runs 0..max(`cnt_p`,`cnt_r`)−1.
  - `p_addr` = min(a, `cnt_p`−1) and `r_addr` = min(a, `cnt_r`−1). Both addresses hold once their count is reached.
  - The P stream is valid one cycle after an address with a < `cnt_p`. The R stream is valid on the same rule with `cnt_r`.
  - Each enabled lane computes popcount(main XOR slave) over `DES_W` bits, saturated to `HD_W`, for each valid stream.
  - A lane updates its per-stream minimum and coordinate only on a strictly smaller distance, so the lowest address wins a tie.
  - A zero count leaves that stream's minimum at all-ones, and the lane then fails any enabled check on that stream.
- **DRAIN:** one cycle for the final RAM word. Then go to EMIT with lane pointer k = 0.
- **EMIT:** examine lane k.
  - Lane k qualifies if it is enabled and:
    - (`MODE[0]`=0 or minP < `MATCH_TH`), and
    - (`MODE[1]`=0 or (minR < `MATCH_TH`, column distance < `PSR` and row distance ≤ `ROW_TOL`)).
  - Distances are computed as unsigned absolute differences.
  - If lane k qualifies, drive `dout_valid`=1 and hold `dout` stable until `dout_ready`. Advance k on the handshake.
  - If lane k does not qualify, advance k in 1 cycle with no output.
  - After lane `N_LANES`−1:
    - `base` += n.
    - If `base` = `cnt_l`, go to DONE.
    - Otherwise go to LOAD.
- **DONE:** `match_done`=1 for one cycle, then go to IDLE.
- `start` is ignored outside IDLE.
- Asserting `rst` mid-frame aborts immediately with no partial output.

## Timing
- Reset values:
  - state IDLE
  - all addresses 0
  - `dout` 0, `dout_valid` 0, `busy` 0, `match_done` 0
  - lane registers 0
- `busy` rises the cycle after a sampled `start`.
- Batch latency with `dout_ready` held at 1: n + 1 (LOAD) + max(`cnt_p`,`cnt_r`) (SCAN) + 1 (DRAIN) + `N_LANES` (EMIT) cycles.
- `dout_valid` is registered. Once asserted, `dout_valid` and `dout` do not change until the handshake completes.
- Results leave in lane order, which is ascending left-RAM address.

## Structure
- Package `match_pkg` holds:
  - the state enum
  - the `COOR_W` row/column slice helpers
  - an absolute-difference function
  - a popcount function
- Sub-module `match_lane`, one instance per lane via generate, contains:
  - the main descriptor register
  - the two HD units
  - the running minimum and coordinate registers for P and R
  - `clear`, `load`, `en_p`, `en_r` controls
- The top level holds the FSM, the address counters and the emit mux.

## Test plan
- `cnt_l`=4, `cnt_p`=`cnt_r`=8; a P word and an R word at address 5 are identical to main 2; R col = main col + 3 -> exactly one output, lane 2, minP = minR = 0, `dout` = `{coorR5, coorP5, coorM2}`.
- `cnt_l`=6, `N_LANES`=4, all qualifying -> two batches (n = 4, then n = 2) giving 6 outputs in address order; `match_done` pulses once.
- `dout_ready` low for 10 cycles during EMIT -> `dout_valid` and `dout` held constant; no loss or duplication.
- Column distance = `PSR` (5) with HD = 0 -> rejected. With `MODE`=2'b01 the same case -> accepted.
- Two R words with equal minimum HD at addresses 3 and 7 -> coorR of address 3 reported. `cnt_p`=0 with `MODE[0]`=1 -> no outputs.
- `rst` low during SCAN -> `busy`, `dout_valid` and all addresses drop to 0 asynchronously; a new `start` runs a clean frame.
